tt_sweep_ctrl: RTL and testbench

- Sequencer that sweeps every input minterm through an external combinational 7-input Boolean function and captures its complete truth table.
- Drives the function's inputs x0..x6 and samples its single output each step.
- Assembles the samples into a 128-bit truth table for classification.
- Start/busy/done handshake with the classification host; optional on-chip compare against an expected table.

---
 rtl/tt_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks x_out through all 2**NUM_INPUTS minterms and captures f_in into tt.
// Optional on-chip compare against expected_tt is enabled by defining TT_SWEEP_COMPARE_EN.
module tt_sweep_ctrl #(
   parameter int NUM_INPUTS    = 7,
   parameter int SETTLE_CYCLES = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   output logic [NUM_INPUTS-1:0]        x_out,
   input  logic                         f_in,
   output logic                         busy,
   output logic                         done,
   output logic                         tt_valid,
   output logic [(2**NUM_INPUTS)-1:0]   tt
`ifdef TT_SWEEP_COMPARE_EN
   ,
   input  logic [(2**NUM_INPUTS)-1:0]   expected_tt,
   output logic                         match,
   output logic [NUM_INPUTS-1:0]        mismatch_idx
`endif
);

   localparam int TT_W  = 2**NUM_INPUTS;
   localparam int IDX_W = NUM_INPUTS + 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TT_W - 1);
   localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [TT_W-1:0]     tt_q, tt_d;
   logic                tt_valid_q, tt_valid_d;
   logic                done_q, done_d;
   logic [NUM_INPUTS-1:0] cur_idx;
   logic                accept;
   logic                sample;
   logic                finish;

   assign cur_idx = idx_q[NUM_INPUTS-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         tt_q       <= '0;
         tt_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         tt_q       <= tt_d;
         tt_valid_q <= tt_valid_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      tt_d       = tt_q;
      tt_valid_d = tt_valid_q;
      done_d     = 1'b0;
      accept     = 1'b0;
      sample     = 1'b0;
      finish     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // abort outranks start in IDLE, so a simultaneous request is dropped
            if (start && !abort) begin
               accept     = 1'b1;
               state_d    = SWEEP;
               idx_d      = '0;
               cnt_d      = SETTLE_LD;
               tt_d       = '0;
               tt_valid_d = 1'b0;
            end
         end
         SWEEP: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               sample        = 1'b1;
               tt_d[cur_idx] = f_in;
               if (idx_q == LAST_IDX) begin
                  finish     = 1'b1;
                  state_d    = IDLE;
                  idx_d      = '0;
                  done_d     = 1'b1;
                  tt_valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  cnt_d = SETTLE_LD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign x_out    = cur_idx;
   assign busy     = (state_q == SWEEP);
   assign done     = done_q;
   assign tt_valid = tt_valid_q;
   assign tt       = tt_q;

`ifdef TT_SWEEP_COMPARE_EN
   logic                  fail_q, fail_d;
   logic [NUM_INPUTS-1:0] fidx_q, fidx_d;
   logic                  match_q, match_d;
   logic [NUM_INPUTS-1:0] midx_q, midx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_q  <= 1'b0;
         fidx_q  <= '0;
         match_q <= 1'b0;
         midx_q  <= '0;
      end else begin
         fail_q  <= fail_d;
         fidx_q  <= fidx_d;
         match_q <= match_d;
         midx_q  <= midx_d;
      end
   end

   // Only the first differing sample is latched, giving the lowest mismatching minterm.
   always_comb begin
      fail_d  = fail_q;
      fidx_d  = fidx_q;
      match_d = match_q;
      midx_d  = midx_q;
      if (accept) begin
         fail_d  = 1'b0;
         fidx_d  = '0;
         match_d = 1'b0;
         midx_d  = '0;
      end
      if (sample && (f_in != expected_tt[cur_idx]) && !fail_q) begin
         fail_d = 1'b1;
         fidx_d = cur_idx;
      end
      if (finish) begin
         match_d = !fail_d;
         midx_d  = fail_d ? fidx_d : '0;
      end
   end

   assign match        = match_q;
   assign mismatch_idx = midx_q;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: stimulus queues expected tables, a done-triggered monitor checks them.
// A second instance with SETTLE_CYCLES=2 checks the stretched hold and latency.
module tb_tt_sweep_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [6:0]   x_out;
   logic         f_in;
   logic         busy, done, tt_valid;
   logic [127:0] tt;

   logic         start2 = 1'b0;
   logic [6:0]   x_out2;
   logic         f_in2;
   logic         busy2, done2, tt_valid2;
   logic [127:0] tt2;

   logic [127:0] exp_cmp = '0;
   int           mode = 0;
   logic [127:0] rtab = '0;
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;
   int           busy_cnt = 0;
   logic         prev_done = 1'b0;

   typedef struct {
      logic [127:0] tt;
      int           e0;
      logic         m;
      logic [6:0]   mi;
   } exp_t;
   exp_t sbq[$];

   localparam logic [127:0] MAJ_TT = 128'hfee8e8e8e8e8e880fee8e8e8e8e8e880;

`ifdef TT_SWEEP_COMPARE_EN
   logic       match, match2;
   logic [6:0] mismatch_idx, mismatch_idx2;
`endif

   tt_sweep_ctrl #(.NUM_INPUTS(7), .SETTLE_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .x_out(x_out), .f_in(f_in), .busy(busy), .done(done),
      .tt_valid(tt_valid), .tt(tt)
`ifdef TT_SWEEP_COMPARE_EN
      , .expected_tt(exp_cmp), .match(match), .mismatch_idx(mismatch_idx)
`endif
   );

   tt_sweep_ctrl #(.NUM_INPUTS(7), .SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
      .x_out(x_out2), .f_in(f_in2), .busy(busy2), .done(done2),
      .tt_valid(tt_valid2), .tt(tt2)
`ifdef TT_SWEEP_COMPARE_EN
      , .expected_tt(128'h0), .match(match2), .mismatch_idx(mismatch_idx2)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural functions under test, indexed by mode.
   function automatic logic fmodel(input int m, input logic [6:0] x, input logic [127:0] r);
      logic [2:0] lo;
      logic       m3;
      lo = x[2:0];
      m3 = (lo[0] & lo[1]) | (lo[0] & lo[2]) | (lo[1] & lo[2]);
      case (m)
         0: return 1'b0;
         1: return x[0];
         2: return x[6];
         3: begin
            if (x[5:3] == 3'b000) return &lo;
            else if (x[5:3] == 3'b111) return |lo;
            else return m3;
         end
         default: return r[x];
      endcase
   endfunction

   assign f_in  = fmodel(mode, x_out, rtab);
   assign f_in2 = x_out2[0];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else begin
         if (done) begin
            exp_t e;
            check("done_single_cycle", {127'h0, prev_done}, 128'h0);
            if (sbq.size() == 0) begin
               check("unexpected_done", 128'h1, 128'h0);
            end else begin
               e = sbq.pop_front();
               check("tt", tt, e.tt);
               check("tt_valid_at_done", {127'h0, tt_valid}, 128'h1);
               check("busy_at_done", {127'h0, busy}, 128'h0);
               check("x_out_at_done", {121'h0, x_out}, 128'h0);
               check("latency", 128'(cyc - e.e0), 128'd128);
               check("busy_cycles", 128'(busy_cnt), 128'd128);
`ifdef TT_SWEEP_COMPARE_EN
               check("match", {127'h0, match}, {127'h0, e.m});
               check("mismatch_idx", {121'h0, mismatch_idx}, {121'h0, e.mi});
`endif
            end
            busy_cnt = 0;
         end else if (busy) begin
            busy_cnt++;
         end else begin
            busy_cnt = 0;
         end
         prev_done = done;
      end
   end

   // Starts a sweep at the current negedge and returns at the negedge showing done.
   task automatic run_sweep(input int m, input int flip, input bit glitch);
      exp_t e;
      mode = m;
      rtab = {$urandom, $urandom, $urandom, $urandom};
      if (m == 3) e.tt = MAJ_TT;
      else for (int i = 0; i < 128; i++) e.tt[i] = fmodel(m, 7'(i), rtab);
      exp_cmp = e.tt;
      if (flip >= 0) exp_cmp[flip] = ~exp_cmp[flip];
      e.m  = (flip < 0);
      e.mi = (flip < 0) ? 7'd0 : 7'(flip);
      e.e0 = cyc + 1;
      sbq.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", {127'h0, busy}, 128'h1);
      check("tt_valid_cleared", {127'h0, tt_valid}, 128'h0);
      check("tt_cleared", tt, 128'h0);
      if (glitch) begin
         repeat (30) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 200; i++) begin
         if (done) break;
         @(negedge clk);
      end
      if (!done) check("done_timeout", 128'h0, 128'h1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] last_tt;
      repeat (3) @(negedge clk);
      check("rst_x_out", {121'h0, x_out}, 128'h0);
      check("rst_busy", {127'h0, busy}, 128'h0);
      check("rst_done", {127'h0, done}, 128'h0);
      check("rst_tt_valid", {127'h0, tt_valid}, 128'h0);
      check("rst_tt", tt, 128'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_sweep(0, -1, 1'b0);
      @(negedge clk);
      run_sweep(1, -1, 1'b0);
      @(negedge clk);
      run_sweep(2, -1, 1'b0);
      @(negedge clk);
      run_sweep(3, -1, 1'b1);
      @(negedge clk);
      run_sweep(3, 5, 1'b0);
      // back-to-back: second start lands in the done cycle
      run_sweep(4, -1, 1'b0);
      run_sweep(4, int'($urandom_range(0, 127)), 1'b0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         run_sweep(int'($urandom_range(0, 4)), -1, 1'b0);
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
      end
      last_tt = tt;

      // abort (alone or with start) in IDLE changes nothing
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("idle_abort_busy", {127'h0, busy}, 128'h0);
      check("idle_abort_tt_valid", {127'h0, tt_valid}, 128'h1);
      check("idle_abort_tt", tt, last_tt);
      @(negedge clk);

      // abort at idx 40
      mode = 4;
      rtab = '1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_idx", {121'h0, x_out}, 128'd40);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", {127'h0, busy}, 128'h0);
      check("abort_tt_valid", {127'h0, tt_valid}, 128'h0);
      check("abort_x_out", {121'h0, x_out}, 128'h0);
      repeat (140) @(negedge clk);

      // async reset at idx 77
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (77) @(negedge clk);
      check("reset_idx", {121'h0, x_out}, 128'd77);
      rst_n = 1'b0;
      #1;
      check("midrst_x_out", {121'h0, x_out}, 128'h0);
      check("midrst_busy", {127'h0, busy}, 128'h0);
      check("midrst_done", {127'h0, done}, 128'h0);
      check("midrst_tt_valid", {127'h0, tt_valid}, 128'h0);
      check("midrst_tt", tt, 128'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (140) @(negedge clk);
      check("no_done_after_reset", {127'h0, tt_valid}, 128'h0);
      run_sweep(4, -1, 1'b0);
      @(negedge clk);

      // SETTLE_CYCLES=2 instance
      begin
         int e0;
         e0 = cyc + 1;
         start2 = 1'b1;
         @(negedge clk);
         start2 = 1'b0;
         for (int k = 0; k < 9; k++) begin
            check("settle_hold", {121'h0, x_out2}, 128'(k / 3));
            @(negedge clk);
         end
         for (int i = 0; i < 450; i++) begin
            if (done2) break;
            @(negedge clk);
         end
         check("settle_done_seen", {127'h0, done2}, 128'h1);
         check("settle_latency", 128'(cyc - e0), 128'd384);
         check("settle_tt", tt2, {32{4'hA}});
         check("settle_tt_valid", {127'h0, tt_valid2}, 128'h1);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 128'(sbq.size()), 128'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
